// File: rtl/fb_ddram_writer.sv
// Buffers renderer framebuffer writes in a DEPTH-entry FIFO and drains them as single-beat Avalon writes.
// Two edges from request to DDRAM_WE; ch_ready drops only when the FIFO is full; DDRAM_BUSY holds the beat.
module fb_ddram_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 29
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [AW-1:0] ch_addr,
  input  logic [63:0]   ch_din,
  input  logic [7:0]    ch_be,
  input  logic          ch_req,
  output logic          ch_ready,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [AW-1:0] DDRAM_ADDR,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE,
  output logic          DDRAM_RD,
  output logic [4:0]    level,
  output logic          idle,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [4:0] FULL = 5'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   din;
    logic [7:0]    be;
  } entry_t;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          push, load;

  assign ch_ready       = (count != FULL);
  assign push           = ch_req & ch_ready;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign DDRAM_WE       = (state == S_WRITE);
  assign level          = count;
  assign idle           = (state == S_IDLE) && (count == 5'd0);

  // count is the registered value, so a push on this edge is never visible to load
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != 5'd0) begin
          load      = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!DDRAM_BUSY) begin
          if (count != 5'd0) load = 1'b1;
          else               state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= '{addr: ch_addr, din: ch_din, be: ch_be};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) rd_ptr <= rd_ptr + PW'(1);
      case ({push, load})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // output registers only move on a load, which implies WE low or the beat accepted
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= 64'd0;
      DDRAM_BE   <= 8'd0;
    end else if (load) begin
      DDRAM_ADDR <= mem[rd_ptr].addr;
      DDRAM_DIN  <= mem[rd_ptr].din;
      DDRAM_BE   <= mem[rd_ptr].be;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                   overflow <= 1'b0;
    else if (ch_req && !ch_ready) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_fb_ddram_writer.sv
// Scoreboard bench: requests are queued by the driver, resolved against a capacity model, and matched to DDRAM beats.
module tb_fb_ddram_writer;
  localparam int DEPTH = 4;
  localparam int AW    = 29;

  typedef struct {
    logic [AW-1:0] addr;
    logic [63:0]   din;
    logic [7:0]    be;
  } req_t;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ch_addr;
  logic [63:0]   ch_din;
  logic [7:0]    ch_be;
  logic          ch_req;
  logic          ch_ready;
  logic          DDRAM_BUSY;
  logic [7:0]    DDRAM_BURSTCNT;
  logic [AW-1:0] DDRAM_ADDR;
  logic [63:0]   DDRAM_DIN;
  logic [7:0]    DDRAM_BE;
  logic          DDRAM_WE;
  logic          DDRAM_RD;
  logic [4:0]    level;
  logic          idle;
  logic          overflow;

  fb_ddram_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be), .ch_req(ch_req), .ch_ready(ch_ready),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .DDRAM_RD(DDRAM_RD),
    .level(level), .idle(idle), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0, fails = 0;
  req_t req_q[$];
  req_t exp_q[$];
  int pending = 0;      // accepted requests whose beat has not yet been accepted
  logic ovf_m = 1'b0;
  int beats = 0, we_cycles = 0, we_rises = 0, ready_low = 0, lvl_max = 0;
  logic have_prev = 1'b0, prev_hold = 1'b0, prev_we = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [63:0]   prev_din;
  logic [7:0]    prev_be;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] b);
    req_t r;
    r.addr = a; r.din = d; r.be = b;
    ch_addr = a; ch_din = d; ch_be = b; ch_req = 1'b1;
    req_q.push_back(r);
    tick();
    ch_req = 1'b0;
  endtask

  // Monitor: mid-cycle view of what the coming edge will do
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      exp_q.delete();
      pending   = 0;
      ovf_m     = 1'b0;
      have_prev = 1'b0;
      prev_we   = 1'b0;
    end else begin
      int   pend0;
      logic acc_ok;
      req_t r, e;
      pend0  = pending;
      acc_ok = (pend0 <= DEPTH);
      if (have_prev) begin
        check("we_sequence", 64'(DDRAM_WE), 64'(exp_we));
        if (prev_hold) begin
          check("hold_addr", 64'(DDRAM_ADDR), 64'(prev_addr));
          check("hold_din", DDRAM_DIN, prev_din);
          check("hold_be", 64'(DDRAM_BE), 64'(prev_be));
        end
      end
      check("ch_ready", 64'(ch_ready), 64'(acc_ok));
      check("idle", 64'(idle), 64'(pend0 == 0));
      check("level", 64'(level) + 64'(DDRAM_WE), 64'(pend0));
      check("overflow", 64'(overflow), 64'(ovf_m));
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (!ch_ready) ready_low++;
      if (DDRAM_WE) we_cycles++;
      if (DDRAM_WE && !prev_we) we_rises++;

      if (DDRAM_WE && !DDRAM_BUSY) exp_we = (pend0 >= 2);
      else if (DDRAM_WE)           exp_we = 1'b1;
      else                         exp_we = (pend0 >= 1);
      prev_hold = DDRAM_WE && DDRAM_BUSY;
      prev_addr = DDRAM_ADDR; prev_din = DDRAM_DIN; prev_be = DDRAM_BE;
      prev_we   = DDRAM_WE;
      have_prev = 1'b1;

      if (DDRAM_WE && !DDRAM_BUSY) begin
        beats++;
        pending--;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_unexpected: addr 0x%0h with empty scoreboard", DDRAM_ADDR);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", 64'(DDRAM_ADDR), 64'(e.addr));
          check("beat_din", DDRAM_DIN, e.din);
          check("beat_be", 64'(DDRAM_BE), 64'(e.be));
        end
      end
      if (ch_req) begin
        if (req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_queue: ch_req seen with no queued stimulus");
        end else begin
          r = req_q.pop_front();
          if (acc_ok) begin
            exp_q.push_back(r);
            pending++;
          end else begin
            ovf_m = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mb, mw, mr;
    rst_n = 1'b0; ch_req = 1'b0; ch_addr = '0; ch_din = '0; ch_be = '0; DDRAM_BUSY = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_ready", 64'(ch_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_we", 64'(DDRAM_WE), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_addr", 64'(DDRAM_ADDR), 64'd0);
    check("rst_din", DDRAM_DIN, 64'd0);
    check("rst_be", 64'(DDRAM_BE), 64'd0);
    check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    check("rd", 64'(DDRAM_RD), 64'd0);

    // single write: WE one cycle, two edges after the request
    mb = beats; mw = we_cycles;
    send(29'h0600000, 64'h0123456789ABCDEF, 8'hFF);
    check("single_we_n1", 64'(DDRAM_WE), 64'd0);
    tick();
    check("single_we_n2", 64'(DDRAM_WE), 64'd1);
    check("single_addr", 64'(DDRAM_ADDR), 64'h0600000);
    tick();
    check("single_we_off", 64'(DDRAM_WE), 64'd0);
    repeat (3) tick();
    check("single_beats", 64'(beats - mb), 64'd1);
    check("single_we_cycles", 64'(we_cycles - mw), 64'd1);
    check("single_idle", 64'(idle), 64'd1);

    // busy stall: five stalled cycles then acceptance
    mb = beats; mw = we_cycles;
    DDRAM_BUSY = 1'b1;
    send(29'h0600000, 64'h0123456789ABCDEF, 8'hFF);
    repeat (6) tick();
    DDRAM_BUSY = 1'b0;
    repeat (4) tick();
    check("stall_beats", 64'(beats - mb), 64'd1);
    check("stall_we_cycles", 64'(we_cycles - mw), 64'd6);

    // back-to-back
    mb = beats; mr = we_rises; lvl_max = 0; ready_low = 0;
    for (int i = 0; i < 4; i++) send(29'(32'h10 + i), {$urandom, $urandom}, 8'(8'hF0 | i));
    repeat (6) tick();
    check("b2b_beats", 64'(beats - mb), 64'd4);
    check("b2b_contiguous", 64'(we_rises - mr), 64'd1);
    check("b2b_level_peak", 64'(lvl_max <= 3), 64'd1);
    check("b2b_ready_low", 64'(ready_low), 64'd0);

    // overflow: 4 in FIFO + 1 in output register, sixth dropped
    mb = beats;
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(29'(32'h200 + i), {$urandom, $urandom}, 8'($urandom));
      if (i == 3) check("ovf_ready_after4", 64'(ch_ready), 64'd1);
      if (i == 4) check("ovf_ready_after5", 64'(ch_ready), 64'd0);
    end
    check("ovf_set", 64'(overflow), 64'd1);
    DDRAM_BUSY = 1'b0;
    repeat (10) tick();
    check("ovf_beats", 64'(beats - mb), 64'd5);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // reset mid-write
    DDRAM_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) send(29'(32'h300 + i), {$urandom, $urandom}, 8'($urandom));
    tick();
    check("prerst_we", 64'(DDRAM_WE), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_we", 64'(DDRAM_WE), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_idle", 64'(idle), 64'd1);
    check("arst_overflow", 64'(overflow), 64'd0);
    tick();
    rst_n = 1'b1;
    DDRAM_BUSY = 1'b0;
    mb = beats; mw = we_cycles;
    repeat (10) tick();
    check("postrst_beats", 64'(beats - mb), 64'd0);
    check("postrst_we", 64'(we_cycles - mw), 64'd0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      DDRAM_BUSY = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 1) == 1) begin
        send(29'($urandom), {$urandom, $urandom}, 8'($urandom));
      end else begin
        ch_req = 1'b0;
        tick();
      end
    end
    ch_req = 1'b0;
    DDRAM_BUSY = 1'b0;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || pending != 0); c++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("drain_idle", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
